// File: rtl/dff_asynchronous_sr_if.sv
// ---------------------------------------------------------------------------
// dff_asynchronous_sr_if
// Bundles the data-side signals of the set/reset storage cell.
//   set  : asynchronous, active-high set request (driven by master)
//   d    : WIDTH-bit data input (driven by master)
//   q    : WIDTH-bit stored value (driven by slave)
//   qbar : WIDTH-bit bitwise complement of q (driven by slave)
// The clock and the synchronous reset stay plain ports on the cell.
// ---------------------------------------------------------------------------
interface dff_asynchronous_sr_if #(
  parameter int WIDTH = 1
);

  logic             set;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  // Master drives the stimulus side and observes the stored value.
  modport master (
    output set,
    output d,
    input  q,
    input  qbar
  );

  // Slave is the storage cell itself.
  modport slave (
    input  set,
    input  d,
    output q,
    output qbar
  );

endinterface

// File: rtl/dff_asynchronous_sr.sv
// ---------------------------------------------------------------------------
// dff_asynchronous_sr
// WIDTH-bit D flip-flop with an asynchronous active-high set and a
// synchronous active-high reset. Intended for sticky flags (error latches,
// interrupt status) that must go high immediately on an event and are only
// cleared on a clock edge.
//
// Parameters:
//   WIDTH       : number of stored bits
//   SET_VALUE   : value forced onto q while set is high
//   RESET_VALUE : value loaded into q on a clock edge with reset high
// Ports:
//   clk   : sole clock, rising-edge active
//   reset : synchronous active-high reset
//   bus   : slave side of dff_asynchronous_sr_if (set, d, q, qbar)
//
// Priority: set (async) > reset (sync) > d (sync).
// ---------------------------------------------------------------------------
module dff_asynchronous_sr #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  dff_asynchronous_sr_if.slave  bus
);

  logic             set_s;
  logic [WIDTH-1:0] q_r;

  // Local copy so the asynchronous set can appear in the edge list.
  assign set_s = bus.set;

  // Storage register: set acts on its own rising edge and holds q while high;
  // after set drops, q keeps SET_VALUE until the next clk edge applies
  // reset or d as usual.
  always_ff @(posedge clk or posedge set_s) begin
    if (set_s) begin
      q_r <= SET_VALUE;
    end else if (reset) begin
      q_r <= RESET_VALUE;
    end else begin
      q_r <= bus.d;
    end
  end

  // qbar is derived from the same register, so the two never agree in any bit.
  assign bus.q    = q_r;
  assign bus.qbar = ~q_r;

endmodule

// File: tb/tb_dff_asynchronous_sr.sv
// ---------------------------------------------------------------------------
// tb_dff_asynchronous_sr
// Self-checking bench for dff_asynchronous_sr. A 1-bit instance covers the
// behavioural scenarios; an 8-bit instance covers the width case. Expected
// values are pushed to a queue when stimulus is driven and popped when the
// output is sampled 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_dff_asynchronous_sr;

  logic clk;
  logic clk_run;
  logic reset;

  int n_checks;
  int n_fail;

  logic       exp_q1 [$];
  logic [7:0] exp_q8 [$];

  dff_asynchronous_sr_if #(.WIDTH(1)) bus1 ();
  dff_asynchronous_sr_if #(.WIDTH(8)) bus8 ();

  dff_asynchronous_sr #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  dff_asynchronous_sr #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  // 10 ns clock, rising at 5, 15, 25 ...; can be parked low via clk_run.
  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Change inputs 1 ns before the next rising edge.
  task automatic to_drive_point();
    @(negedge clk);
    #4;
  endtask

  // Move to 1 ns after the next rising edge.
  task automatic to_check_point();
    @(posedge clk);
    #1;
  endtask

  task automatic check_narrow(input string name);
    logic e;
    n_checks++;
    if (exp_q1.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q1.pop_front();
      if (bus1.q !== e || bus1.qbar !== ~e) begin
        n_fail++;
        $display("FAIL %s: q=%b qbar=%b, expected q=%b qbar=%b",
                 name, bus1.q, bus1.qbar, e, ~e);
      end
    end
  endtask

  task automatic test_reset();
    to_drive_point();
    bus1.set = 1'b0; reset = 1'b1; bus1.d = 1'b1;
    exp_q1.push_back(1'b0);
    to_check_point();
    check_narrow("reset_load");
    to_drive_point();
    reset = 1'b0; bus1.d = 1'b1;
    exp_q1.push_back(1'b1);
    to_check_point();
    check_narrow("reset_release");
  endtask

  task automatic test_data_capture();
    logic [3:0] seq;
    seq = 4'b0110;  // applied LSB first: 0,1,1,0
    for (int i = 0; i < 4; i++) begin
      to_drive_point();
      bus1.set = 1'b0; reset = 1'b0; bus1.d = seq[i];
      exp_q1.push_back(seq[i]);
      to_check_point();
      check_narrow("data_capture");
    end
  endtask

  task automatic test_async_set();
    // q is 0 here from the data sequence; park clk low after a falling edge.
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    bus1.set = 1'b1;
    #1;
    n_checks++;
    if (bus1.q !== 1'b1 || bus1.qbar !== 1'b0) begin
      n_fail++;
      $display("FAIL async_set_immediate: q=%b qbar=%b, expected q=1 qbar=0",
               bus1.q, bus1.qbar);
    end
    bus1.set = 1'b0; bus1.d = 1'b0; reset = 1'b0;
    #1;
    n_checks++;
    if (bus1.q !== 1'b1 || bus1.qbar !== 1'b0) begin
      n_fail++;
      $display("FAIL async_set_hold: q=%b qbar=%b, expected q=1 qbar=0",
               bus1.q, bus1.qbar);
    end
    exp_q1.push_back(1'b0);
    clk_run = 1'b1;
    to_check_point();
    check_narrow("async_set_release_edge");
  endtask

  task automatic test_set_over_reset();
    to_drive_point();
    bus1.set = 1'b1; reset = 1'b1; bus1.d = 1'b0;
    exp_q1.push_back(1'b1);
    to_check_point();
    check_narrow("set_over_reset_1");
    exp_q1.push_back(1'b1);
    to_check_point();
    check_narrow("set_over_reset_2");
    to_drive_point();
    bus1.set = 1'b0;
    exp_q1.push_back(1'b0);
    to_check_point();
    check_narrow("reset_after_set");
    // Set rising mid-cycle while reset is pending wins immediately.
    #3;
    bus1.set = 1'b1;
    #1;
    n_checks++;
    if (bus1.q !== 1'b1 || bus1.qbar !== 1'b0) begin
      n_fail++;
      $display("FAIL set_mid_reset: q=%b qbar=%b, expected q=1 qbar=0",
               bus1.q, bus1.qbar);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] combo;
    logic       e;
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      to_drive_point();
      bus1.set = combo[2]; reset = combo[1]; bus1.d = combo[0];
      if (combo[2]) e = 1'b1;
      else if (combo[1]) e = 1'b0;
      else e = combo[0];
      exp_q1.push_back(e);
      to_check_point();
      check_narrow($sformatf("sweep_s%0b_r%0b_d%0b", combo[2], combo[1], combo[0]));
    end
  endtask

  task automatic check_wide(input string name);
    logic [7:0] e;
    n_checks++;
    if (exp_q8.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q8.pop_front();
      if (bus8.q !== e || bus8.qbar !== ~e) begin
        n_fail++;
        $display("FAIL %s: q=%h qbar=%h, expected q=%h qbar=%h",
                 name, bus8.q, bus8.qbar, e, ~e);
      end
    end
  endtask

  task automatic test_width();
    to_drive_point();
    bus1.set = 1'b0; reset = 1'b0; bus8.set = 1'b0; bus8.d = 8'hA5;
    exp_q8.push_back(8'hA5);
    to_check_point();
    check_wide("width_data");
    to_drive_point();
    bus8.set = 1'b1;
    #0.5;
    exp_q8.push_back(8'hFF);
    check_wide("width_set_immediate");
    exp_q8.push_back(8'hFF);
    to_check_point();
    check_wide("width_set_edge");
    to_drive_point();
    bus8.set = 1'b0; reset = 1'b1;
    exp_q8.push_back(8'h00);
    to_check_point();
    check_wide("width_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    reset = 1'b0; bus8.set = 1'b0;
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 255));
      to_drive_point();
      bus8.d = v;
      exp_q8.push_back(v);
      to_check_point();
      check_wide("back_to_back");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_run  = 1'b1;
    reset    = 1'b0;
    bus1.set = 1'b0;
    bus1.d   = 1'b0;
    bus8.set = 1'b0;
    bus8.d   = 8'h00;

    test_reset();
    test_data_capture();
    test_async_set();
    test_set_over_reset();
    test_sweep();
    test_width();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
